// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports and the shared ALU port of alu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipes and ALU.
interface alu_arbiter_if;
    logic        req0_order;
    logic [2:0]  req0_func3;
    logic        req0_mode_flag;
    logic        req0_imm_flag;
    logic        req0_ext_flag;
    logic [31:0] req0_rs1;
    logic [31:0] req0_rs2;
    logic        req0_accepted;
    logic        req0_done;
    logic [31:0] req0_rd;

    logic        req1_order;
    logic [2:0]  req1_func3;
    logic        req1_mode_flag;
    logic        req1_imm_flag;
    logic        req1_ext_flag;
    logic [31:0] req1_rs1;
    logic [31:0] req1_rs2;
    logic        req1_accepted;
    logic        req1_done;
    logic [31:0] req1_rd;

    logic        err;
    logic        busy;

    logic        alu_order;
    logic [2:0]  alu_func3;
    logic        alu_mode_flag;
    logic        alu_imm_flag;
    logic        alu_ext_flag;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic        alu_accepted;
    logic        alu_done;
    logic [31:0] alu_rd;

    modport slave (
        input  req0_order, req0_func3, req0_mode_flag, req0_imm_flag, req0_ext_flag,
               req0_rs1, req0_rs2,
        input  req1_order, req1_func3, req1_mode_flag, req1_imm_flag, req1_ext_flag,
               req1_rs1, req1_rs2,
        output req0_accepted, req0_done, req0_rd,
        output req1_accepted, req1_done, req1_rd,
        output err, busy,
        output alu_order, alu_func3, alu_mode_flag, alu_imm_flag, alu_ext_flag,
               alu_rs1, alu_rs2,
        input  alu_accepted, alu_done, alu_rd
    );

    modport master (
        output req0_order, req0_func3, req0_mode_flag, req0_imm_flag, req0_ext_flag,
               req0_rs1, req0_rs2,
        output req1_order, req1_func3, req1_mode_flag, req1_imm_flag, req1_ext_flag,
               req1_rs1, req1_rs2,
        input  req0_accepted, req0_done, req0_rd,
        input  req1_accepted, req1_done, req1_rd,
        input  err, busy,
        input  alu_order, alu_func3, alu_mode_flag, alu_imm_flag, alu_ext_flag,
               alu_rs1, alu_rs2,
        output alu_accepted, alu_done, alu_rd
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two issue ports, with an ALU handshake
// sequencer and a watchdog that aborts operations whose done never arrives.
module alu_arbiter #(
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic        owner;
    logic        rr;
    logic [2:0]  op_func3;
    logic        op_mode;
    logic        op_imm;
    logic        op_ext;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;
    logic [31:0] result;
    logic        err_flag;
    logic [CW-1:0] cnt;

    logic        grant_valid;
    logic        grant_id;
    logic [2:0]  sel_func3;
    logic        sel_mode;
    logic        sel_imm;
    logic        sel_ext;
    logic [31:0] sel_rs1;
    logic [31:0] sel_rs2;

    // Grants are only possible while no op is in flight; rr breaks ties.
    always_comb begin
        grant_valid = ((state == IDLE) || (state == RESP)) &&
                      (bus.req0_order || bus.req1_order);
        if (bus.req0_order && bus.req1_order)
            grant_id = rr;
        else
            grant_id = bus.req1_order;
        sel_func3 = grant_id ? bus.req1_func3     : bus.req0_func3;
        sel_mode  = grant_id ? bus.req1_mode_flag : bus.req0_mode_flag;
        sel_imm   = grant_id ? bus.req1_imm_flag  : bus.req0_imm_flag;
        sel_ext   = grant_id ? bus.req1_ext_flag  : bus.req0_ext_flag;
        sel_rs1   = grant_id ? bus.req1_rs1       : bus.req0_rs1;
        sel_rs2   = grant_id ? bus.req1_rs2       : bus.req0_rs2;
    end

    assign bus.req0_accepted = grant_valid && !grant_id;
    assign bus.req1_accepted = grant_valid &&  grant_id;

    assign bus.req0_done = (state == RESP) && !owner;
    assign bus.req1_done = (state == RESP) &&  owner;
    assign bus.req0_rd   = result;
    assign bus.req1_rd   = result;
    assign bus.err       = (state == RESP) && err_flag;
    assign bus.busy      = (state == ISSUE) || (state == WAIT);

    assign bus.alu_order     = (state == ISSUE);
    assign bus.alu_func3     = op_func3;
    assign bus.alu_mode_flag = op_mode;
    assign bus.alu_imm_flag  = op_imm;
    assign bus.alu_ext_flag  = op_ext;
    assign bus.alu_rs1       = op_rs1;
    assign bus.alu_rs2       = op_rs2;

    // RESP doubles as an arbitration slot so back-to-back ops take two cycles each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr       <= 1'b0;
            op_func3 <= '0;
            op_mode  <= 1'b0;
            op_imm   <= 1'b0;
            op_ext   <= 1'b0;
            op_rs1   <= '0;
            op_rs2   <= '0;
            result   <= '0;
            err_flag <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    err_flag <= 1'b0;
                    if (grant_valid) begin
                        owner    <= grant_id;
                        rr       <= ~grant_id;
                        op_func3 <= sel_func3;
                        op_mode  <= sel_mode;
                        op_imm   <= sel_imm;
                        op_ext   <= sel_ext;
                        op_rs1   <= sel_rs1;
                        op_rs2   <= sel_rs2;
                        state    <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.alu_done) begin
                        result <= bus.alu_rd;
                        state  <= RESP;
                    end else if (bus.alu_accepted) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.alu_done) begin
                        result <= bus.alu_rd;
                        state  <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        result   <= '0;
                        err_flag <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: instance 0 uses TIMEOUT=64, instance 1 uses TIMEOUT=8
// for the watchdog scenario; each has a small configurable ALU responder.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    int   alu_lat   [2];
    int   alu_stall [2];
    bit   alu_hang  [2];

    alu_arbiter_if bus [2] ();

    function automatic logic [31:0] alu_compute(input logic [2:0] f, input logic m,
                                                input logic e, input logic [31:0] a,
                                                input logic [31:0] b);
        if (e) begin
            case (f)
                3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd7:    return (b == 0) ? a : a % b;
                default: return 32'h0;
            endcase
        end
        case (f)
            3'd0:    return m ? a - b : a + b;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return 32'h0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        int          stall_cnt;
        int          pend_cnt;
        logic        pend;
        logic [31:0] pend_rd;

        alu_arbiter #(.TIMEOUT(g == 0 ? 64 : 8)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );

        // Responder: optional accept stall, then combinational or delayed done.
        always_comb begin
            bus[g].alu_accepted = bus[g].alu_order && (stall_cnt >= alu_stall[g]);
            bus[g].alu_done     = 1'b0;
            bus[g].alu_rd       = '0;
            if (bus[g].alu_accepted && alu_lat[g] == 0 && !alu_hang[g]) begin
                bus[g].alu_done = 1'b1;
                bus[g].alu_rd   = alu_compute(bus[g].alu_func3, bus[g].alu_mode_flag,
                                              bus[g].alu_ext_flag, bus[g].alu_rs1,
                                              bus[g].alu_rs2);
            end else if (pend && pend_cnt == 0) begin
                bus[g].alu_done = 1'b1;
                bus[g].alu_rd   = pend_rd;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stall_cnt <= 0;
                pend      <= 1'b0;
                pend_cnt  <= 0;
                pend_rd   <= '0;
            end else begin
                if (bus[g].alu_order && !bus[g].alu_accepted)
                    stall_cnt <= stall_cnt + 1;
                else
                    stall_cnt <= 0;
                if (bus[g].alu_accepted && alu_lat[g] > 0 && !alu_hang[g]) begin
                    pend     <= 1'b1;
                    pend_cnt <= alu_lat[g] - 1;
                    pend_rd  <= alu_compute(bus[g].alu_func3, bus[g].alu_mode_flag,
                                            bus[g].alu_ext_flag, bus[g].alu_rs1,
                                            bus[g].alu_rs2);
                end else if (pend && pend_cnt == 0) begin
                    pend <= 1'b0;
                end else if (pend) begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
        end
    end

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one requester port of instance 0.
    task automatic apply_stimulus(input bit port, input logic order, input logic [2:0] f,
                                  input logic m, input logic e, input logic [31:0] a,
                                  input logic [31:0] b);
        if (!port) begin
            bus[0].req0_order     = order;
            bus[0].req0_func3     = f;
            bus[0].req0_mode_flag = m;
            bus[0].req0_imm_flag  = 1'b0;
            bus[0].req0_ext_flag  = e;
            bus[0].req0_rs1       = a;
            bus[0].req0_rs2       = b;
        end else begin
            bus[0].req1_order     = order;
            bus[0].req1_func3     = f;
            bus[0].req1_mode_flag = m;
            bus[0].req1_imm_flag  = 1'b0;
            bus[0].req1_ext_flag  = e;
            bus[0].req1_rs1       = a;
            bus[0].req1_rs2       = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b0;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            alu_lat[i]   = 0;
            alu_stall[i] = 0;
            alu_hang[i]  = 1'b0;
        end
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus[1].req0_order = 1'b0; bus[1].req0_func3 = 3'd0; bus[1].req0_mode_flag = 1'b0;
        bus[1].req0_imm_flag = 1'b0; bus[1].req0_ext_flag = 1'b0;
        bus[1].req0_rs1 = 32'h0; bus[1].req0_rs2 = 32'h0;
        bus[1].req1_order = 1'b0; bus[1].req1_func3 = 3'd0; bus[1].req1_mode_flag = 1'b0;
        bus[1].req1_imm_flag = 1'b0; bus[1].req1_ext_flag = 1'b0;
        bus[1].req1_rs1 = 32'h0; bus[1].req1_rs2 = 32'h0;

        #2 rst = 1'b1;
        #1;
        check_output("rst_ctl", 32'({bus[0].req0_accepted, bus[0].req1_accepted,
                     bus[0].req0_done, bus[0].req1_done, bus[0].err, bus[0].busy,
                     bus[0].alu_order, bus[0].alu_func3, bus[0].alu_mode_flag,
                     bus[0].alu_imm_flag, bus[0].alu_ext_flag}), 32'h0);
        check_output("rst_rd", bus[0].req0_rd, 32'h0);
        check_output("rst_rs", bus[0].alu_rs1 | bus[0].alu_rs2, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle hold");
        for (int c = 0; c < 10; c++) begin
            sample();
            check_output("idle_ctl", 32'({bus[0].req0_accepted, bus[0].req1_accepted,
                         bus[0].req0_done, bus[0].req1_done, bus[0].err, bus[0].busy,
                         bus[0].alu_order}), 32'h0);
        end

        $display("[TB] single ADD on req0");
        step(); apply_stimulus(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7); sample();
        check_output("add_acc", 32'({bus[0].req0_accepted, bus[0].req1_accepted,
                     bus[0].alu_order}), 32'b100);
        step(); apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        check_output("add_issue", 32'({bus[0].alu_order, bus[0].busy, bus[0].req0_done}),
                     32'b110);
        check_output("add_rs1", bus[0].alu_rs1, 32'd5);
        check_output("add_rs2", bus[0].alu_rs2, 32'd7);
        step(); sample();
        check_output("add_done", 32'({bus[0].req0_done, bus[0].req1_done, bus[0].err,
                     bus[0].busy}), 32'b1000);
        check_output("add_rd", bus[0].req0_rd, 32'd12);
        step(); sample();
        check_output("add_after", 32'({bus[0].req0_done, bus[0].req1_done}), 32'h0);

        $display("[TB] contention");
        do_reset();
        step();
        apply_stimulus(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'd10, 32'd3);
        apply_stimulus(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 32'hF0, 32'hFF);
        sample();
        check_output("ct_c0", 32'({bus[0].req0_accepted, bus[0].req1_accepted}), 32'b10);
        step(); sample();
        check_output("ct_c1", 32'({bus[0].alu_order, bus[0].alu_mode_flag,
                     bus[0].req0_accepted, bus[0].req1_accepted}), 32'b1100);
        step(); sample();
        check_output("ct_c2", 32'({bus[0].req0_done, bus[0].req1_done,
                     bus[0].req0_accepted, bus[0].req1_accepted}), 32'b1001);
        check_output("ct_c2_rd", bus[0].req0_rd, 32'd7);
        step(); sample();
        check_output("ct_c3_op", 32'({bus[0].alu_order, bus[0].alu_func3}), 32'b1100);
        check_output("ct_c3_rs1", bus[0].alu_rs1, 32'hF0);
        step(); sample();
        check_output("ct_c4", 32'({bus[0].req0_done, bus[0].req1_done,
                     bus[0].req0_accepted, bus[0].req1_accepted}), 32'b0110);
        check_output("ct_c4_rd", bus[0].req1_rd, 32'h0F);
        step(); sample();
        step(); sample();
        check_output("ct_c6", 32'({bus[0].req0_done, bus[0].req1_done,
                     bus[0].req0_accepted, bus[0].req1_accepted}), 32'b1001);
        check_output("ct_c6_rd", bus[0].req0_rd, 32'd7);
        step();
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        sample();
        step(); sample();
        check_output("ct_c8", 32'({bus[0].req0_done, bus[0].req1_done,
                     bus[0].req0_accepted, bus[0].req1_accepted}), 32'b0100);
        check_output("ct_c8_rd", bus[0].req1_rd, 32'h0F);
        step(); sample();
        check_output("ct_c9", 32'({bus[0].busy, bus[0].req0_done, bus[0].req1_done}), 32'h0);

        $display("[TB] ALU accept stall");
        alu_stall[0] = 2;
        step(); apply_stimulus(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1); sample();
        check_output("st_acc", 32'(bus[0].req0_accepted), 32'h1);
        step(); apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        check_output("st_c1", 32'({bus[0].alu_order, bus[0].busy}), 32'b11);
        step(); sample();
        check_output("st_c2", 32'({bus[0].alu_order, bus[0].req0_done}), 32'b10);
        step(); sample();
        check_output("st_c3", 32'({bus[0].alu_order, bus[0].req0_done}), 32'b10);
        step(); sample();
        check_output("st_c4", 32'({bus[0].alu_order, bus[0].req0_done}), 32'b01);
        check_output("st_rd", bus[0].req0_rd, 32'd2);
        alu_stall[0] = 0;

        $display("[TB] multi-cycle DIVU");
        alu_lat[0] = 33;
        step(); apply_stimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7); sample();
        check_output("dv_acc", 32'(bus[0].req0_accepted), 32'h1);
        step(); apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        check_output("dv_issue", 32'({bus[0].alu_order, bus[0].alu_ext_flag,
                     bus[0].alu_func3}), 32'b11101);
        step(); sample();
        check_output("dv_wait", 32'({bus[0].busy, bus[0].alu_order}), 32'b10);
        for (int c = 3; c <= 34; c++) begin
            step();
            if (c == 10) apply_stimulus(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
            sample();
            check_output("dv_hold", 32'({bus[0].req1_accepted, bus[0].req0_done}), 32'h0);
        end
        step(); alu_lat[0] = 0; sample();
        check_output("dv_done", 32'({bus[0].req0_done, bus[0].err, bus[0].req1_accepted}),
                     32'b101);
        check_output("dv_rd", bus[0].req0_rd, 32'd14);
        step(); apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        check_output("dv_r1_issue", 32'(bus[0].alu_order), 32'h1);
        check_output("dv_r1_rs1", bus[0].alu_rs1, 32'd1);
        step(); sample();
        check_output("dv_r1_done", 32'({bus[0].req1_done, bus[0].err}), 32'b10);
        check_output("dv_r1_rd", bus[0].req1_rd, 32'd3);

        $display("[TB] watchdog timeout");
        alu_hang[1] = 1'b1;
        step();
        bus[1].req0_order = 1'b1; bus[1].req0_func3 = 3'd0;
        bus[1].req0_rs1 = 32'd9; bus[1].req0_rs2 = 32'd9;
        sample();
        check_output("to_acc", 32'(bus[1].req0_accepted), 32'h1);
        step(); bus[1].req0_order = 1'b0; sample();
        check_output("to_issue", 32'({bus[1].alu_order, bus[1].busy}), 32'b11);
        for (int c = 2; c <= 9; c++) begin
            step(); sample();
            check_output("to_wait", 32'({bus[1].busy, bus[1].req0_done, bus[1].err}),
                         32'b100);
        end
        step(); sample();
        check_output("to_done", 32'({bus[1].req0_done, bus[1].err, bus[1].busy}), 32'b110);
        check_output("to_rd", bus[1].req0_rd, 32'h0);
        step();
        alu_hang[1] = 1'b0;
        bus[1].req1_order = 1'b1; bus[1].req1_func3 = 3'd6;
        bus[1].req1_rs1 = 32'h1; bus[1].req1_rs2 = 32'h2;
        sample();
        check_output("to_c11", 32'({bus[1].err, bus[1].req0_done, bus[1].req1_accepted}),
                     32'b001);
        step(); bus[1].req1_order = 1'b0; sample();
        check_output("to_r1_issue", 32'(bus[1].alu_order), 32'h1);
        step(); sample();
        check_output("to_r1_done", 32'({bus[1].req1_done, bus[1].err}), 32'b10);
        check_output("to_r1_rd", bus[1].req1_rd, 32'h3);

        $display("[TB] reset during WAIT");
        alu_lat[0] = 33;
        step(); apply_stimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 32'd100, 32'd7); sample();
        step(); apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        repeat (3) begin step(); sample(); end
        check_output("rw_pre", 32'(bus[0].busy), 32'h1);
        step();
        #2 rst = 1'b1;
        #1;
        check_output("rw_ctl", 32'({bus[0].busy, bus[0].alu_order, bus[0].alu_func3,
                     bus[0].alu_ext_flag, bus[0].req0_done, bus[0].err}), 32'h0);
        check_output("rw_rs", bus[0].alu_rs1 | bus[0].alu_rs2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        alu_lat[0] = 0;
        for (int c = 0; c < 40; c++) begin
            sample();
            check_output("rw_quiet", 32'({bus[0].req0_done, bus[0].req1_done, bus[0].err,
                         bus[0].busy}), 32'h0);
        end
        step();
        apply_stimulus(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 32'hC, 32'hA);
        apply_stimulus(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 32'h1, 32'h2);
        sample();
        check_output("rw_rr", 32'({bus[0].req0_accepted, bus[0].req1_accepted}), 32'b10);
        step(); apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        check_output("rw_issue", 32'(bus[0].alu_order), 32'h1);
        step(); sample();
        check_output("rw_done", 32'({bus[0].req0_done, bus[0].err, bus[0].req1_accepted}),
                     32'b101);
        check_output("rw_rd", bus[0].req0_rd, 32'h8);
        step(); apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0); sample();
        step(); sample();
        check_output("rw_r1_done", 32'(bus[0].req1_done), 32'h1);
        check_output("rw_r1_rd", bus[0].req1_rd, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer that shares one `alu` instance between two issue ports (e.g. integer pipe and address-generation pipe). It accepts an operation from one requester at a time and latches its operands. It drives the ALU's order/accepted/done handshake, covering single-cycle internal ops and multi-cycle `divu`/`remu`, and returns the result to the winning requester as a one-cycle done pulse. A watchdog aborts operations whose ALU done never arrives.

## Interface
- `TIMEOUT`, 64: maximum cycles in WAIT before the operation is aborted (≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; the ALU instance is reset by the same event.
- `reqN_order`  in  1  request valid, N∈{0,1}; held high with stable operands until `reqN_accepted`.
- `reqN_func3`  in  3  ALU func3, N∈{0,1}.
- `reqN_mode_flag`, `reqN_imm_flag`, `reqN_ext_flag`  in  1 each  ALU mode/imm/extension flags, N∈{0,1}.
- `reqN_rs1`, `reqN_rs2`  in  32 each  operands, N∈{0,1}.
- `reqN_accepted`  out  1  one-cycle grant pulse; operands latched this cycle.
- `reqN_done`  out  1  one-cycle result pulse.
- `reqN_rd`  out  32  result; both ports driven from the shared result register, valid only with `reqN_done`.
- `err`  out  1  one-cycle pulse alongside `reqN_done` when the op was aborted by timeout.
- `alu_order`, `alu_func3`, `alu_mode_flag`, `alu_imm_flag`, `alu_ext_flag`, `alu_rs1`, `alu_rs2`  out  1/3/1/1/1/32/32  to ALU.
- `alu_accepted`, `alu_done`  in  1 each; `alu_rd`  in  32  from ALU; `alu_done`/`alu_rd` may be combinational in the cycle of `alu_order`.
- `busy`  out  1  high in ISSUE and WAIT.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registers: state, owner (1b), rr pointer (1b, the preferred requester), latched op (func3, 3 flags, rs1, rs2), result (32b), err flag, timeout counter (ceil(log2(TIMEOUT+1)) bits).
- Arbitration in IDLE and RESP: one `reqN_order` high → grant N. Both high → grant rr. Grant asserts `reqN_accepted` combinationally, latches op and owner, and sets rr = ~N. Next state is ISSUE. No request → IDLE.
- ISSUE: `alu_order`=1, ALU op outputs = latched op.
  - `alu_done` → result←`alu_rd`, go to RESP.
  - else `alu_accepted` → go to WAIT, counter←0.
  - else (ALU busy) → stay in ISSUE, order held.
- WAIT: `alu_order`=0.
  - `alu_done` → result←`alu_rd`, go to RESP.
  - counter==TIMEOUT-1 without done → result←0, err flag←1, go to RESP.
  - else counter+1.
- RESP: `reqOwner_done`=1, `err`=err flag, err flag cleared. Arbitrates as IDLE in the same cycle; go to ISSUE on grant, else IDLE.
- ALU op outputs are the latched op in every state; `alu_order` is 0 outside ISSUE.
- A requester dropping order before accepted is tolerated: requests are sampled per cycle only. An order is never granted to an owner whose op is in flight, because arbitration happens only in IDLE/RESP.
- Reset (any state, including mid-WAIT): state=IDLE, rr=0, owner=0, latched op=0, result=0, err flag=0, counter=0. All outputs read 0 and the in-flight op is discarded with no done.

## Timing
- Single-cycle op, idle arbiter: accepted in cycle t, `alu_order` in t+1, `reqN_done` in t+2. Back-to-back throughput is 1 op per 2 cycles.
- Multi-cycle op: `reqN_done` one cycle after `alu_done`.
- ALU stalling `alu_accepted`: each stall cycle adds one cycle of latency.
- Timeout: done+err exactly TIMEOUT+1 cycles after the ISSUE-cycle `alu_accepted`.
- `reqN_accepted`, `alu_order`, and grant outputs are combinational from state/inputs. `reqN_done`, `reqN_rd`, and `err` depend on registers only.
- Only one of `req0_accepted`/`req1_accepted` is high per cycle, and likewise for done.

## Test plan
- Reset, then hold all idle 10 cycles -> every output 0, `busy`=0, `alu_order`=0 throughout.
- req0 ADD rs1=5 rs2=7 at cycle 0 -> `req0_accepted` cycle 0, `alu_order` cycle 1, `req0_done` cycle 2 with rd=12; `req1_*` outputs stay 0.
- Both request at cycle 0 after reset: req0 SUB (mode=1, imm=0) 10,3 and req1 XOR 0xF0,0xFF -> req0 accepted cycle 0, done cycle 2 rd=7. req1 accepted cycle 2 (RESP), done cycle 4 rd=0x0F. Repeated contention alternates grants 1,0,1.
- req0 DIVU ext=1 100,7 with ALU done 33 cycles after order; req1 orders during WAIT -> `req0_done` one cycle after `alu_done`, rd=14, err=0. req1 accepted in that RESP cycle, not earlier.
- TIMEOUT=8, ALU model accepts but never asserts done -> `req0_done` with rd=0 and `err`=1, 9 cycles after acceptance. The arbiter then serves a fresh req1 OR 0x1,0x2 -> rd=3, err=0.
- `rst` asserted asynchronously mid-WAIT -> outputs 0 immediately, no `reqN_done` for the aborted op. After release a new req0 AND 0xC,0xA -> rd=0x8 with normal timing, and rr favours req0.
